// File: rtl/shk_spi_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : shk_spi_arbiter
//  Description : Round-robin arbiter that shares one shake-bus slave port
//                (the SPI shake bridge) between NUM_REQ shake masters. One
//                transaction is in flight at a time, and each transaction has
//                a response timeout. Sticky error info is kept for monitoring.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    i_sys_clk / i_sys_resetn   clock, asynchronous active-low reset
//    s_shk_req_*                requester side (packed per-requester slices
//                               in, one-hot ready and broadcast response out)
//    m_shk_spi_*                bridge side (request out, response in)
//    i_err_clr                  clears the sticky error bits [1:0]
//    m_err_arb_info1            {last timed-out index[1:0], drop, timeout}
// ============================================================================
module shk_spi_arbiter #(
    parameter int NUM_REQ     = 2,
    parameter int WD_SHK_DATA = 8,
    parameter int WD_SHK_ADDR = 8,
    parameter int TIMEOUT_CYC = 1024,
    parameter int WD_ERR_INFO = 4
) (
    input  logic                           i_sys_clk,
    input  logic                           i_sys_resetn,
    input  logic [NUM_REQ-1:0]             s_shk_req_valid,
    input  logic [NUM_REQ-1:0]             s_shk_req_msync,
    input  logic [NUM_REQ*WD_SHK_DATA-1:0] s_shk_req_mdata,
    input  logic [NUM_REQ*WD_SHK_ADDR-1:0] s_shk_req_maddr,
    output logic [NUM_REQ-1:0]             s_shk_req_ready,
    output logic                           s_shk_req_ssync,
    output logic [WD_SHK_DATA-1:0]         s_shk_req_sdata,
    output logic [WD_SHK_ADDR-1:0]         s_shk_req_saddr,
    output logic                           m_shk_spi_valid,
    output logic                           m_shk_spi_msync,
    output logic [WD_SHK_DATA-1:0]         m_shk_spi_mdata,
    output logic [WD_SHK_ADDR-1:0]         m_shk_spi_maddr,
    input  logic                           m_shk_spi_ready,
    input  logic                           m_shk_spi_ssync,
    input  logic [WD_SHK_DATA-1:0]         m_shk_spi_sdata,
    input  logic [WD_SHK_ADDR-1:0]         m_shk_spi_saddr,
    input  logic                           i_err_clr,
    output logic [WD_ERR_INFO-1:0]         m_err_arb_info1
);

    localparam int GW = (NUM_REQ > 2) ? 2 : 1;
    localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_RESP    = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    state_t                    state_q;
    logic [GW-1:0]             ptr_q;
    logic [GW-1:0]             gnt_q;
    logic [CW-1:0]             cnt_q;
    logic                      drop_q;
    logic                      m_valid_q;
    logic                      m_msync_q;
    logic [WD_SHK_DATA-1:0]    m_mdata_q;
    logic [WD_SHK_ADDR-1:0]    m_maddr_q;
    logic [NUM_REQ-1:0]        s_ready_q;
    logic                      s_ssync_q;
    logic [WD_SHK_DATA-1:0]    s_sdata_q;
    logic [WD_SHK_ADDR-1:0]    s_saddr_q;
    logic [WD_ERR_INFO-1:0]    err_q;
    logic [WD_ERR_INFO-1:0]    err_d;

    logic [WD_SHK_DATA-1:0]    req_mdata_w [NUM_REQ];
    logic [WD_SHK_ADDR-1:0]    req_maddr_w [NUM_REQ];
    logic                      sel_found_w;
    logic [GW-1:0]             sel_idx_w;
    logic [NUM_REQ-1:0]        gnt_oh_w;
    logic                      to_hit_w;
    logic                      gnt_valid_w;

    // (base + k) mod NUM_REQ, with base < NUM_REQ and k < NUM_REQ
    function automatic logic [GW-1:0] wrap_add(input logic [GW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NUM_REQ) begin
            s = s - NUM_REQ;
        end
        return GW'(s);
    endfunction

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign req_mdata_w[gi] = s_shk_req_mdata[gi*WD_SHK_DATA +: WD_SHK_DATA];
        assign req_maddr_w[gi] = s_shk_req_maddr[gi*WD_SHK_ADDR +: WD_SHK_ADDR];
    end

    // First valid requester at or above the pointer, wrapping around
    always_comb begin
        sel_found_w = 1'b0;
        sel_idx_w   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!sel_found_w && s_shk_req_valid[wrap_add(ptr_q, k)]) begin
                sel_found_w = 1'b1;
                sel_idx_w   = wrap_add(ptr_q, k);
            end
        end
    end

    assign gnt_oh_w    = {{(NUM_REQ-1){1'b0}}, 1'b1} << gnt_q;
    assign to_hit_w    = (cnt_q == CW'(TIMEOUT_CYC - 1));
    assign gnt_valid_w = s_shk_req_valid[gnt_q];

    // Sticky error bits: clear first, then let same-cycle set events win
    always_comb begin
        err_d = err_q;
        if (i_err_clr) begin
            err_d[1:0] = 2'b00;
        end
        if (state_q == ST_ISSUE && !gnt_valid_w) begin
            err_d[1] = 1'b1;
        end
        if (state_q == ST_ISSUE && !m_shk_spi_ready && to_hit_w) begin
            err_d[0]   = 1'b1;
            err_d[3:2] = 2'(gnt_q);
        end
    end

    always_ff @(posedge i_sys_clk or negedge i_sys_resetn) begin
        if (!i_sys_resetn) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            gnt_q     <= '0;
            cnt_q     <= '0;
            drop_q    <= 1'b0;
            m_valid_q <= 1'b0;
            m_msync_q <= 1'b0;
            m_mdata_q <= '0;
            m_maddr_q <= '0;
            s_ready_q <= '0;
            s_ssync_q <= 1'b0;
            s_sdata_q <= '0;
            s_saddr_q <= '0;
            err_q     <= '0;
        end else begin
            err_q     <= err_d;
            s_ready_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (sel_found_w) begin
                        gnt_q     <= sel_idx_w;
                        m_msync_q <= s_shk_req_msync[sel_idx_w];
                        m_mdata_q <= req_mdata_w[sel_idx_w];
                        m_maddr_q <= req_maddr_w[sel_idx_w];
                        m_valid_q <= 1'b1;
                        cnt_q     <= '0;
                        drop_q    <= 1'b0;
                        state_q   <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // The bridge cannot abort, so a dropped request only
                    // suppresses the response pulse once the bridge is done.
                    if (!gnt_valid_w) begin
                        drop_q <= 1'b1;
                    end
                    if (m_shk_spi_ready) begin
                        m_valid_q <= 1'b0;
                        s_ssync_q <= m_shk_spi_ssync;
                        s_sdata_q <= m_shk_spi_sdata;
                        s_saddr_q <= m_shk_spi_saddr;
                        s_ready_q <= (drop_q || !gnt_valid_w) ? '0 : gnt_oh_w;
                        cnt_q     <= '0;
                        state_q   <= ST_RESP;
                    end else if (to_hit_w) begin
                        m_valid_q <= 1'b0;
                        s_ssync_q <= 1'b0;
                        s_sdata_q <= '0;
                        s_saddr_q <= m_maddr_q;
                        s_ready_q <= (drop_q || !gnt_valid_w) ? '0 : gnt_oh_w;
                        cnt_q     <= '0;
                        state_q   <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                ST_RESP: begin
                    if (drop_q) begin
                        ptr_q   <= wrap_add(gnt_q, 1);
                        state_q <= ST_IDLE;
                    end else begin
                        state_q <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    if (!gnt_valid_w) begin
                        ptr_q   <= wrap_add(gnt_q, 1);
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign s_shk_req_ready = s_ready_q;
    assign s_shk_req_ssync = s_ssync_q;
    assign s_shk_req_sdata = s_sdata_q;
    assign s_shk_req_saddr = s_saddr_q;
    assign m_shk_spi_valid = m_valid_q;
    assign m_shk_spi_msync = m_msync_q;
    assign m_shk_spi_mdata = m_mdata_q;
    assign m_shk_spi_maddr = m_maddr_q;
    assign m_err_arb_info1 = err_q;

endmodule
`default_nettype wire
